// File: rtl/lpc_sniffer_pkg.sv
// Shared constants, header layout and serializer state encoding.
// Optional build macro LPC_SERIALIZER_CHECKSUM_EN adds the CSUM state.
package lpc_sniffer_pkg;

   localparam logic [1:0] CYC_IO  = 2'b00;
   localparam logic [1:0] CYC_MEM = 2'b01;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   localparam int HDR_OVF_BIT = 7;
   localparam int HDR_DIR_BIT = 2;
   localparam int HDR_CYC_MSB = 1;
   localparam int HDR_CYC_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_HDR,
      ST_ADDR,
`ifdef LPC_SERIALIZER_CHECKSUM_EN
      ST_CSUM,
`endif
      ST_DATA
   } ser_state_e;

   // Header byte: {ovf, 4'b0, dir, cyctype}.
   function automatic logic [7:0] make_hdr(input logic ovf, input logic dir,
                                           input logic [1:0] cyc);
      logic [7:0] h;
      h = 8'h00;
      h[HDR_OVF_BIT] = ovf;
      h[HDR_DIR_BIT] = dir;
      h[HDR_CYC_MSB:HDR_CYC_LSB] = cyc;
      return h;
   endfunction

   // Index of the first (most significant) address byte sent for a cycle type.
   function automatic logic [1:0] first_addr_idx(input logic [1:0] cyc);
      logic [1:0] idx;
      if (cyc == CYC_IO) begin
         idx = 2'd1;
      end else if (cyc == CYC_MEM) begin
         idx = 2'd3;
      end else begin
         // reserved cycle types are framed exactly like memory cycles
         idx = 2'd3;
      end
      return idx;
   endfunction

endpackage

// File: rtl/lpc_frame_serializer.sv
// LPC record to UART byte-stream framer.
// Frame: A5, header, address (2 bytes IO / 4 bytes memory), data
// and, when built with LPC_SERIALIZER_CHECKSUM_EN, an XOR checksum byte.
//
// state | meaning
// IDLE  | waiting for a record, rec_ready high
// SYNC  | sending the 0xA5 sync byte
// HDR   | sending {ovf, 0000, dir, cyctype}
// ADDR  | sending address bytes, MSB first, index counts down to 0
// DATA  | sending the data byte
// CSUM  | sending XOR of header/address/data bytes (checksum build only)
module lpc_frame_serializer
   import lpc_sniffer_pkg::*;
#(
   parameter int CLOCK_FREQ = 12000000
) (
   input  logic        ext_clock,
   input  logic        ext_reset,
   input  logic        rec_valid,
   output logic        rec_ready,
   input  logic [1:0]  rec_cyctype,
   input  logic        rec_dir,
   input  logic [31:0] rec_addr,
   input  logic [7:0]  rec_data,
   input  logic        ovf_pulse,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy
);

   // Clock frequency is carried for documentation of the instance only.
   localparam int unused_clock_freq = CLOCK_FREQ;

   ser_state_e  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [1:0]  cyc_q, cyc_d;
   logic        dir_q, dir_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        ovf_q, ovf_d;
   // Overflow value frozen into the header so tx_data stays stable under stall.
   logic        hdr_ovf_q, hdr_ovf_d;
`ifdef LPC_SERIALIZER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   logic        accept;

   assign tx_valid  = (state_q != ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign rec_ready = (state_q == ST_IDLE) && !ext_reset;
   assign accept    = tx_valid && tx_ready;

   // Output byte selected from registered frame fields.
   always_comb begin
      tx_data = 8'h00;
      case (state_q)
         ST_SYNC: tx_data = SYNC_BYTE;
         ST_HDR:  tx_data = make_hdr(hdr_ovf_q, dir_q, cyc_q);
         ST_ADDR: tx_data = addr_q[{idx_q, 3'b000} +: 8];
         ST_DATA: tx_data = data_q;
`ifdef LPC_SERIALIZER_CHECKSUM_EN
         ST_CSUM: tx_data = csum_q;
`endif
         default: tx_data = 8'h00;
      endcase
   end

   // Next-state, field capture, overflow flag and checksum accumulation.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cyc_d     = cyc_q;
      dir_d     = dir_q;
      addr_d    = addr_q;
      data_d    = data_q;
      hdr_ovf_d = hdr_ovf_q;
      ovf_d     = ovf_q;
`ifdef LPC_SERIALIZER_CHECKSUM_EN
      csum_d    = csum_q;
`endif

      // Only a reported overflow is cleared; a pulse in the same cycle wins.
      if (state_q == ST_HDR && accept && hdr_ovf_q) begin
         ovf_d = 1'b0;
      end
      if (ovf_pulse) begin
         ovf_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
`ifdef LPC_SERIALIZER_CHECKSUM_EN
            csum_d = 8'h00;
`endif
            if (rec_valid && rec_ready) begin
               cyc_d   = rec_cyctype;
               dir_d   = rec_dir;
               addr_d  = rec_addr;
               data_d  = rec_data;
               idx_d   = first_addr_idx(rec_cyctype);
               state_d = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (accept) begin
               hdr_ovf_d = ovf_d;
               state_d   = ST_HDR;
            end
         end
         ST_HDR: begin
            if (accept) begin
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (accept) begin
               if (idx_q == 2'd0) begin
                  state_d = ST_DATA;
               end else begin
                  idx_d = idx_q - 2'd1;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
`ifdef LPC_SERIALIZER_CHECKSUM_EN
               state_d = ST_CSUM;
`else
               state_d = ST_IDLE;
`endif
            end
         end
`ifdef LPC_SERIALIZER_CHECKSUM_EN
         ST_CSUM: begin
            if (accept) begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

`ifdef LPC_SERIALIZER_CHECKSUM_EN
      if (accept && (state_q == ST_HDR || state_q == ST_ADDR || state_q == ST_DATA)) begin
         csum_d = csum_q ^ tx_data;
      end
`endif
   end

   // State and frame registers with synchronous reset; reset aborts any frame.
   always_ff @(posedge ext_clock) begin
      if (ext_reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= 2'd0;
         cyc_q     <= 2'd0;
         dir_q     <= 1'b0;
         addr_q    <= 32'h0;
         data_q    <= 8'h00;
         ovf_q     <= 1'b0;
         hdr_ovf_q <= 1'b0;
`ifdef LPC_SERIALIZER_CHECKSUM_EN
         csum_q    <= 8'h00;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cyc_q     <= cyc_d;
         dir_q     <= dir_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         ovf_q     <= ovf_d;
         hdr_ovf_q <= hdr_ovf_d;
`ifdef LPC_SERIALIZER_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_lpc_frame_serializer.sv
// Scoreboard bench for lpc_frame_serializer; honours LPC_SERIALIZER_CHECKSUM_EN.
module tb_lpc_frame_serializer;

   logic        ext_clock = 1'b0;
   logic        ext_reset = 1'b1;
   logic        rec_valid = 1'b0;
   logic        rec_ready;
   logic [1:0]  rec_cyctype = 2'b00;
   logic        rec_dir = 1'b0;
   logic [31:0] rec_addr = 32'h0;
   logic [7:0]  rec_data = 8'h00;
   logic        ovf_pulse = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        busy;

   lpc_frame_serializer #(.CLOCK_FREQ(12000000)) dut (
      .ext_clock   (ext_clock),
      .ext_reset   (ext_reset),
      .rec_valid   (rec_valid),
      .rec_ready   (rec_ready),
      .rec_cyctype (rec_cyctype),
      .rec_dir     (rec_dir),
      .rec_addr    (rec_addr),
      .rec_data    (rec_data),
      .ovf_pulse   (ovf_pulse),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy)
   );

   always #5 ext_clock = ~ext_clock;

`ifdef LPC_SERIALIZER_CHECKSUM_EN
   localparam int CSUM_BYTES = 1;
`else
   localparam int CSUM_BYTES = 0;
`endif
   localparam int L_IO = 5 + CSUM_BYTES;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] lit_q[$];
   logic       model_ovf = 1'b0;
   bit         rdy_rand = 1'b0;
   int         cyc_cnt = 0;
   int         sync_cyc[$];
   logic       busy_prev = 1'b0;
   logic       stall_prev = 1'b0;
   logic [7:0] prev_data = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   // Reference frame built straight from the framing rules.
   task automatic push_model(input logic [1:0] cyc, input logic dir,
                             input logic [31:0] addr, input logic [7:0] data,
                             input logic ovf);
      int         n;
      logic [7:0] hdr, b, x;
      n   = (cyc == 2'b00) ? 2 : 4;
      hdr = {ovf, 4'b0000, dir, cyc};
      exp_q.push_back(8'hA5);
      exp_q.push_back(hdr);
      x = hdr;
      for (int i = n - 1; i >= 0; i--) begin
         b = 8'((addr >> (8 * i)) & 32'hFF);
         exp_q.push_back(b);
         x = x ^ b;
      end
      exp_q.push_back(data);
      x = x ^ data;
      if (CSUM_BYTES == 1) exp_q.push_back(x);
   endtask

   // Present one record; caller is 1 time unit after a rising edge.
   task automatic send_rec(input logic [1:0] cyc, input logic dir,
                           input logic [31:0] addr, input logic [7:0] data);
      int g;
      rec_cyctype = cyc;
      rec_dir     = dir;
      rec_addr    = addr;
      rec_data    = data;
      rec_valid   = 1'b1;
      g = 0;
      while (!rec_ready && g < 300) begin
         @(posedge ext_clock); #1;
         g++;
      end
      if (g >= 300) begin
         checks++; errors++;
         $display("FAIL rec_accept_timeout: rec_ready never rose");
         rec_valid = 1'b0;
         lit_q.delete();
         return;
      end
      if (lit_q.size() > 0) begin
         foreach (lit_q[i]) exp_q.push_back(lit_q[i]);
         lit_q.delete();
      end else begin
         push_model(cyc, dir, addr, data, model_ovf);
      end
      model_ovf = 1'b0;
      @(posedge ext_clock); #1;
      rec_valid = 1'b0;
      check("sync_latency_valid", 32'(tx_valid), 32'd1);
      check("sync_latency_data", 32'(tx_data), 32'hA5);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || busy) && g < 3000) begin
         @(posedge ext_clock); #1;
         g++;
      end
      if (g >= 3000) begin
         checks++; errors++;
         $display("FAIL idle_timeout: %0d bytes still expected", exp_q.size());
      end
   endtask

   task automatic lit(input logic [7:0] b);
      lit_q.push_back(b);
   endtask

   always @(posedge ext_clock) cyc_cnt++;

   always @(posedge ext_clock) begin
      #1;
      if (rdy_rand) tx_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: pops the scoreboard on each accepted byte and checks stall stability.
   always @(negedge ext_clock) begin
      if (!ext_reset) begin
         if (busy && !busy_prev) sync_cyc.push_back(cyc_cnt);
         if (stall_prev) begin
            check("stall_hold_valid", 32'(tx_valid), 32'd1);
            check("stall_hold_data", 32'(tx_data), 32'(prev_data));
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_byte: got %0h expected none", tx_data);
            end else begin
               check("frame_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
         end
      end
      busy_prev  = busy && !ext_reset;
      stall_prev = tx_valid && !tx_ready && !ext_reset;
      prev_data  = tx_data;
   end

   initial begin
      int n0;
      int g;
      logic [1:0] c;

      // reset values
      repeat (3) @(posedge ext_clock);
      #1;
      check("reset_rec_ready", 32'(rec_ready), 32'd0);
      check("reset_tx_valid", 32'(tx_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_tx_data", 32'(tx_data), 32'h00);
      ext_reset = 1'b0;
      #1;
      check("post_reset_rec_ready", 32'(rec_ready), 32'd1);
      @(posedge ext_clock); #1;

      // IO write
      lit(8'hA5); lit(8'h04); lit(8'h00); lit(8'h60); lit(8'hF1);
      if (CSUM_BYTES == 1) lit(8'h95);
      send_rec(2'b00, 1'b1, 32'h0000_0060, 8'hF1);
      wait_idle();

      // IO read
      lit(8'hA5); lit(8'h00); lit(8'h00); lit(8'h60); lit(8'h12);
      if (CSUM_BYTES == 1) lit(8'h72);
      send_rec(2'b00, 1'b0, 32'h0000_0060, 8'h12);
      wait_idle();

      // memory read
      lit(8'hA5); lit(8'h01); lit(8'h12); lit(8'h34); lit(8'h56); lit(8'h78); lit(8'h1F);
      if (CSUM_BYTES == 1) lit(8'h16);
      send_rec(2'b01, 1'b0, 32'h1234_5678, 8'h1F);
      wait_idle();

      // back-to-back IO frames: L cycles plus one IDLE cycle apart
      n0 = sync_cyc.size();
      send_rec(2'b00, 1'b1, 32'hABCD_0102, 8'h33);
      send_rec(2'b00, 1'b0, 32'h0000_BEEF, 8'h44);
      wait_idle();
      if (sync_cyc.size() >= n0 + 2)
         check("back_to_back_spacing", 32'(sync_cyc[n0 + 1] - sync_cyc[n0]), 32'(L_IO + 1));
      else
         check("back_to_back_frames", 32'(sync_cyc.size() - n0), 32'd2);

      // backpressure on the 0x34 address byte
      send_rec(2'b01, 1'b1, 32'h1234_5678, 8'h9A);
      g = 0;
      while (!(tx_valid && tx_data == 8'h34) && g < 50) begin
         @(posedge ext_clock); #1;
         g++;
      end
      check("bp_reach_0x34", 32'(tx_data), 32'h34);
      tx_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge ext_clock); #1;
         check("bp_hold_valid", 32'(tx_valid), 32'd1);
         check("bp_hold_data", 32'(tx_data), 32'h34);
      end
      tx_ready = 1'b1;
      wait_idle();

      // overflow during a frame is reported in the next header only
      send_rec(2'b00, 1'b1, 32'h0000_0060, 8'hF1);
      @(posedge ext_clock); #1;
      @(posedge ext_clock); #1;
      ovf_pulse = 1'b1;
      @(posedge ext_clock); #1;
      ovf_pulse = 1'b0;
      wait_idle();
      lit(8'hA5); lit(8'h84); lit(8'h00); lit(8'h60); lit(8'hF1);
      if (CSUM_BYTES == 1) lit(8'h15);
      send_rec(2'b00, 1'b1, 32'h0000_0060, 8'hF1);
      wait_idle();
      lit(8'hA5); lit(8'h04); lit(8'h00); lit(8'h60); lit(8'hF1);
      if (CSUM_BYTES == 1) lit(8'h95);
      send_rec(2'b00, 1'b1, 32'h0000_0060, 8'hF1);
      wait_idle();

      // pulse coincident with HDR acceptance survives into the next frame
      send_rec(2'b00, 1'b1, 32'h0000_0060, 8'hF1);
      @(posedge ext_clock); #1;
      ovf_pulse = 1'b1;
      @(posedge ext_clock); #1;
      ovf_pulse = 1'b0;
      wait_idle();
      lit(8'hA5); lit(8'h84); lit(8'h00); lit(8'h60); lit(8'hF1);
      if (CSUM_BYTES == 1) lit(8'h15);
      send_rec(2'b00, 1'b1, 32'h0000_0060, 8'hF1);
      wait_idle();

      // reset during ADDR aborts the frame
      send_rec(2'b00, 1'b1, 32'h0000_0060, 8'hF1);
      @(posedge ext_clock); #1;
      @(posedge ext_clock); #1;
      ext_reset = 1'b1;
      exp_q.delete();
      model_ovf = 1'b0;
      #1;
      check("midreset_rec_ready", 32'(rec_ready), 32'd0);
      @(posedge ext_clock); #1;
      check("midreset_tx_valid", 32'(tx_valid), 32'd0);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_tx_data", 32'(tx_data), 32'h00);
      ext_reset = 1'b0;
      #1;
      check("midreset_rec_ready_after", 32'(rec_ready), 32'd1);
      send_rec(2'b01, 1'b1, 32'hCAFE_F00D, 8'h5A);
      wait_idle();

      // randomized records with random backpressure
      rdy_rand = 1'b1;
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge ext_clock); #1;
         end
         c = 2'($urandom_range(0, 3));
         send_rec(c, 1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255)));
      end
      rdy_rand = 1'b0;
      tx_ready = 1'b1;
      wait_idle();

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lpc_frame_serializer.md
# lpc_frame_serializer

Turns decoded LPC cycle records into framed byte streams for the UART transmitter, in the `ext_clock` domain. Sits downstream of the LPC record FIFO and upstream of the UART byte transmitter. Each accepted record becomes one frame: sync byte, header, address (2 bytes for IO, 4 for memory), data, and an optional checksum. It also carries a sticky FIFO-overflow indication into the next frame header.

## Interface
- `CLOCK_FREQ`, 12000000: `ext_clock` frequency in Hz; informational only, no functional effect.
- `ext_clock` in 1: the only clock.
- `ext_reset` in 1: synchronous, active-high reset.
- `rec_valid` in 1: a record is presented on the `rec_*` fields.
- `rec_ready` out 1: the block can accept a record.
- `rec_cyctype` in 2: cycle type. 00 = IO, 01 = memory, 1x = reserved (framed as memory).
- `rec_dir` in 1: 0 = read, 1 = write.
- `rec_addr` in 32: cycle address. For IO only bits [15:0] are sent.
- `rec_data` in 8: data byte.
- `ovf_pulse` in 1: single-cycle FIFO-overflow event.
- `tx_data` out 8: output byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the UART accepts the byte.
- `busy` out 1: a frame is in progress (state is not IDLE).

## Operation
- **States:** IDLE, SYNC, HDR, ADDR, DATA, CSUM.
- **IDLE:**
  - `rec_ready`=1.
  - When `rec_valid`&`rec_ready`, all `rec_*` fields are registered and the state goes to SYNC.
  - In every other state `rec_ready`=0.
- **SYNC:** byte 0xA5.
- **HDR:** byte {ovf_flag, 4'b0, dir, cyctype}.
  - Acceptance of the HDR byte clears `ovf_flag`.
- **ADDR:**
  - IO: addr[15:8], then addr[7:0].
  - Memory or reserved: addr[31:24] down to addr[7:0].
  - A 2-bit byte index selects the byte and counts down to 0.
- **DATA:** the data byte.
- **CSUM:** the checksum byte (see Configuration).
- **Frame completion:** after the last byte is accepted, the state returns to IDLE.
- **Overflow flag:**
  - `ovf_pulse` sets the sticky `ovf_flag`.
  - If a set and the HDR-acceptance clear occur in the same cycle, the set wins: the flag stays 1 and is reported in the next frame.
- **Output handshake:**
  - `tx_data` is driven from registered state.
  - `tx_valid`=1 in SYNC through the last byte.
  - `tx_data` must stay stable while `tx_valid`&!`tx_ready`.

## Timing
- **Reset values:** `tx_valid`=0, `tx_data`=0x00, `rec_ready`=0 during reset and 1 in the first cycle after reset, `busy`=0, `ovf_flag`=0, state=IDLE.
- **Latency:** a record accepted at edge N gives `tx_valid`=1 with 0xA5 after edge N.
- **Byte advance:** when `tx_valid`&`tx_ready` at an edge, the next byte appears after that edge. There are no bubbles.
- **Frame length:** IO = 5 bytes, memory = 7 bytes; one more of each with the checksum.
- **Back-to-back records:** with `tx_ready` held high, a frame occupies L cycles plus 1 IDLE cycle.
- **Reset mid-frame:** the frame is aborted and the block returns to the reset values on the next edge. No partial-frame resumption.
- **Idle input:** `rec_valid` while busy is ignored; the record is held upstream by `rec_ready`=0.

## Configuration
- **Macro:** `LPC_SERIALIZER_CHECKSUM_EN`.
- **Defined:**
  - The CSUM state exists.
  - The checksum is the XOR of the HDR, ADDR and DATA bytes, accumulated on acceptance and cleared in IDLE.
  - CSUM is sent after DATA.
- **Undefined:**
  - The CSUM state and the accumulator are removed.
  - DATA acceptance returns the state to IDLE.

## Structure
- **Shared package `lpc_sniffer_pkg`:**
  - Cycle-type constants (CYC_IO=2'b00, CYC_MEM=2'b01).
  - `SYNC_BYTE`=8'hA5.
  - Header bit positions (OVF=7, DIR=2, CYC=1:0).
  - The serializer state enum.
- **Sub-modules:** none. The byte mux, index counter and XOR accumulator live in one module.

## Test plan
- **IO write:** addr 0x0060, data 0xF1, `tx_ready`=1 → bytes A5 04 00 60 F1. With the checksum, an extra 0x95.
- **IO read:** addr 0x0060, data 0x12 → A5 00 00 60 12. With the checksum, an extra 0x72.
- **Memory read:** addr 0x12345678, data 0x1F → A5 01 12 34 56 78 1F. With the checksum, an extra 0x16.
- **Backpressure:** `tx_ready`=0 for 10 cycles while 0x34 is presented → `tx_data` is held at 0x34 with `tx_valid`=1. No byte is lost or duplicated.
- **Overflow:** `ovf_pulse` during frame 1, then an IO write to 0x0060 with data 0xF1 → frame 2 HDR=0x84 and frame 3 HDR=0x04. A pulse coincident with HDR acceptance → the next frame HDR also has bit 7 set.
- **Reset mid-frame:** `ext_reset` during ADDR → `tx_valid`=0 next cycle, then `rec_ready`=1. The next record produces a clean frame starting with A5.
